// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_ctrl (+ fulladder_str)
// Purpose  : Bit-serial adder sequencer. Operands are taken over a
//            valid/ready handshake, then fed LSB-first, one bit per clock,
//            through a single shared 1-bit full adder. The carry is
//            registered between bits. The result is returned over a second
//            valid/ready handshake.
// Ports    : clk, rst_n            - rising-edge clock, async active-low reset
//            in_valid/in_ready     - operand handshake (ready only in IDLE)
//            a, b, cin             - operands, sampled on accept
//            out_valid/out_ready   - result handshake (valid only in HOLD)
//            sum, cout             - a+b+cin mod 2^WIDTH, carry out of MSB
//            busy                  - high while RUN or HOLD
// Revision : 1.0 - initial release
// ============================================================================

// Structural 1-bit full adder: the shared arithmetic resource.
module fulladder_str (
  output logic s,
  output logic c,
  input  logic a,
  input  logic b,
  input  logic cin
);
  wire p;
  wire g;
  wire t;

  xor u_x0 (p, a, b);
  xor u_x1 (s, p, cin);
  and u_a0 (g, a, b);
  and u_a1 (t, p, cin);
  or  u_o0 (c, g, t);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] SUM_MSB  = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic             c_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic             s_bit;
  logic             c_bit;

  fulladder_str u_fa (
    .s   (s_bit),
    .c   (c_bit),
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .cin (c_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // in_ready is registered, so it first rises one clock after reset
          // release; an accept needs both the state and the visible ready.
          if (in_ready_q && in_valid) begin
            a_sh_q     <= a;
            b_sh_q     <= b;
            c_q        <= cin;
            cnt_q      <= '0;
            sum_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_RUN;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        S_RUN: begin
          // New sum bit enters at the MSB so that after WIDTH shifts the
          // LSB-first result lands in natural bit order.
          sum_q  <= (sum_q >> 1) | (s_bit ? SUM_MSB : '0);
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          c_q    <= c_bit;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            cout_q      <= c_bit;
            out_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire
